jk_ff_driver: RTL and testbench

Closed-loop excitation driver for the single-bit JK flip-flop (`JK_FF`). It accepts a requested next state over a valid/ready handshake and derives the J/K excitation from the flip-flop's fed-back current state. It drives J/K for exactly one clock edge, then checks that `q`/`qb` reached the target, and counts failures. It sits on the stimulus side of `JK_FF` and shares its clock.

---
 rtl/jk_pkg.sv | 24 ++
 rtl/jk_ff_driver_if.sv | 21 ++
 rtl/jk_sat_cnt.sv | 23 ++
 rtl/jk_ff_driver.sv | 118 +++++++++++
 tb/tb_jk_ff_driver.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jk_pkg.sv
// Shared types and the excitation rule for the JK flip-flop driver.
package jk_pkg;

  // Driver sequencing: accept a request, drive J/K for one edge, then check q.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // Excitation returned as {J, K}. The term the flop does not care about
  // is driven with dc: 0 gives hold/set/reset coding, 1 gives toggle coding.
  function automatic logic [1:0] jk_excite(input logic q0, input logic tgt, input logic dc);
    logic [1:0] v;
    case ({q0, tgt})
      2'b00:   v = {1'b0, dc};
      2'b01:   v = {1'b1, dc};
      2'b10:   v = {dc, 1'b1};
      default: v = {dc, 1'b0};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/jk_ff_driver_if.sv
// Request channel into the JK flip-flop driver.
// Handshake: a request transfers on a rising edge where tgt_valid and
// tgt_ready are both high; tgt is only meaningful while tgt_valid is high,
// and a request presented while tgt_ready is low is ignored, not queued.
interface jk_ff_driver_if;
  logic tgt;
  logic tgt_valid;
  logic tgt_ready;

  modport master (
    output tgt,
    output tgt_valid,
    input  tgt_ready
  );

  modport slave (
    input  tgt,
    input  tgt_valid,
    output tgt_ready
  );
endinterface

// File: rtl/jk_sat_cnt.sv
// Event counter that either saturates at all-ones or wraps around.
module jk_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_sat,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  // Count enabled events; in saturate mode the all-ones value is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en && !(i_sat && (&r_cnt))) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/jk_ff_driver.sv
// Closed-loop excitation driver for a single JK flip-flop on the same clock.
// Takes a requested next state, drives J/K for one edge from the fed-back q,
// then checks q/qb one edge later and keeps pass/fail statistics.
module jk_ff_driver
  import jk_pkg::*;
#(
  parameter logic DC_MODE = 1'b0,
  parameter int   CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  jk_ff_driver_if.slave    bus,
  output logic             j,
  output logic             k,
  input  logic             q,
  input  logic             qb,
  output logic             done,
  output logic             err,
  output logic             rail_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] xfer_cnt
);
  state_t     r_state;
  logic       r_tgt;
  logic       r_ready;
  logic       r_j;
  logic       r_k;
  logic       r_done;
  logic       r_err;
  logic       r_rail;

  logic       w_chk;
  logic       w_rail_hit;
  logic       w_fail;
  logic [1:0] w_exc;

  // The compare happens on the edge that leaves CHECK; q == qb means the
  // flop's outputs are not complementary and the check fails regardless of q.
  assign w_chk      = (r_state == ST_CHECK);
  assign w_rail_hit = (q == qb);
  assign w_fail     = (q != r_tgt) || w_rail_hit;
  assign w_exc      = jk_excite(q, bus.tgt, DC_MODE);

  // Sequencer with registered J/K, handshake and result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_tgt   <= 1'b0;
      r_ready <= 1'b1;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rail  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.tgt_valid) begin
            r_tgt      <= bus.tgt;
            {r_j, r_k} <= w_exc;
            r_ready    <= 1'b0;
            r_state    <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          // The flop samples J/K on this edge; release them afterwards.
          r_j     <= 1'b0;
          r_k     <= 1'b0;
          r_state <= ST_CHECK;
        end
        ST_CHECK: begin
          r_done  <= 1'b1;
          r_err   <= w_fail;
          if (w_rail_hit) begin
            r_rail <= 1'b1;
          end
          // Ready rises together with done so the next request can be
          // accepted on the edge that ends the done cycle.
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_j     <= 1'b0;
          r_k     <= 1'b0;
        end
      endcase
    end
  end

  // Failed checks saturate so a long fault run never reads as few failures.
  jk_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_chk & w_fail),
    .i_sat (1'b1),
    .o_cnt (err_cnt)
  );

  // Completed checks wrap; this is a transfer sequence count.
  jk_sat_cnt #(.W(CNT_W)) u_xfer_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_chk),
    .i_sat (1'b0),
    .o_cnt (xfer_cnt)
  );

  assign bus.tgt_ready = r_ready;
  assign j             = r_j;
  assign k             = r_k;
  assign done          = r_done;
  assign err           = r_err;
  assign rail_err      = r_rail;
endmodule

// File: tb/tb_jk_ff_driver.sv
// Bench for jk_ff_driver: two instances (hold/set/reset coding with 8-bit
// counters, toggle coding with 2-bit counters), each closing the loop
// through a behavioural JK flip-flop with injectable faults.
module tb_jk_ff_driver;
  localparam int RW = 18;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT wiring ----------------
  jk_ff_driver_if bus0();
  jk_ff_driver_if bus1();

  logic [1:0] tgt_v   = '0;
  logic [1:0] valid_v = '0;
  logic [1:0] ff_q    = '0;
  logic [1:0] stuck   = '0;
  logic [1:0] rail    = '0;
  logic [1:0] pre_en  = '0;
  logic [1:0] pre_val = '0;

  logic       j0, k0, done0, err0, rail0;
  logic       j1, k1, done1, err1, rail1;
  logic [7:0] ecnt0, xcnt0;
  logic [1:0] ecnt1, xcnt1;
  logic [1:0] ready_v, j_v, k_v, done_v, err_v, rail_v, q_v, qb_v;

  assign bus0.tgt       = tgt_v[0];
  assign bus0.tgt_valid = valid_v[0];
  assign bus1.tgt       = tgt_v[1];
  assign bus1.tgt_valid = valid_v[1];
  assign ready_v = {bus1.tgt_ready, bus0.tgt_ready};
  assign j_v     = {j1, j0};
  assign k_v     = {k1, k0};
  assign done_v  = {done1, done0};
  assign err_v   = {err1, err0};
  assign rail_v  = {rail1, rail0};
  // A rail fault ties both flop outputs low.
  assign q_v     = ~rail & ff_q;
  assign qb_v    = ~rail & ~ff_q;

  jk_ff_driver #(.DC_MODE(1'b0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .j(j0), .k(k0), .q(q_v[0]), .qb(qb_v[0]),
    .done(done0), .err(err0), .rail_err(rail0), .err_cnt(ecnt0), .xfer_cnt(xcnt0)
  );
  jk_ff_driver #(.DC_MODE(1'b1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .j(j1), .k(k1), .q(q_v[1]), .qb(qb_v[1]),
    .done(done1), .err(err1), .rail_err(rail1), .err_cnt(ecnt1), .xfer_cnt(xcnt1)
  );

  // Behavioural JK flip-flop (never reset by the driver); stuck freezes it.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pre_en[i]) ff_q[i] <= pre_val[i];
      else if (!stuck[i]) begin
        case ({j_v[i], k_v[i]})
          2'b10:   ff_q[i] <= 1'b1;
          2'b01:   ff_q[i] <= 1'b0;
          2'b11:   ff_q[i] <= ~ff_q[i];
          default: ;
        endcase
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  int phase[2];
  int done_seen[2];
  int m_ecnt[2];
  int m_xcnt[2];
  logic m_rail[2];
  logic [RW-1:0] exp_q0[$];
  logic [RW-1:0] exp_q1[$];
  logic [1:0]    exp_jk0[$];
  logic [1:0]    exp_jk1[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic report_fail(string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s @%0t: event missing or unexpected", name, $time);
  endtask

  function automatic logic [RW-1:0] act_resp(int i);
    if (i == 0) return {err_v[0], rail_v[0], ecnt0, xcnt0};
    return {err_v[1], rail_v[1], 6'b0, ecnt1, 6'b0, xcnt1};
  endfunction

  // Reference model: evaluated when a request is seen to be accepted.
  task automatic model_accept(int i);
    logic q0, qc, fail, dc, t;
    int mx;
    logic [1:0] jk;
    logic [RW-1:0] resp;
    t  = tgt_v[i];
    dc = (i == 1);
    mx = (i == 0) ? 255 : 3;
    q0 = rail[i] ? 1'b0 : ff_q[i];
    // A healthy flop lands on the target; a frozen one keeps its value.
    qc = rail[i] ? 1'b0 : (stuck[i] ? ff_q[i] : t);
    fail = rail[i] || (qc != t);
    m_rail[i] = m_rail[i] | rail[i];
    if (fail && m_ecnt[i] != mx) m_ecnt[i] = m_ecnt[i] + 1;
    m_xcnt[i] = (m_xcnt[i] + 1) % (mx + 1);
    // J must set a 0 that should become 1; K must clear a 1 that should become 0.
    jk = {(q0 ? dc : t), (q0 ? ~t : dc)};
    resp = {fail, m_rail[i], 8'(m_ecnt[i]), 8'(m_xcnt[i])};
    if (i == 0) begin exp_q0.push_back(resp); exp_jk0.push_back(jk); end
    else begin exp_q1.push_back(resp); exp_jk1.push_back(jk); end
  endtask

  task automatic mon_step(int i);
    logic [RW-1:0] e;
    logic [1:0] ejk;
    if (!rst_n) begin
      phase[i] = 0; m_ecnt[i] = 0; m_xcnt[i] = 0; m_rail[i] = 1'b0;
      if (i == 0) begin exp_q0.delete(); exp_jk0.delete(); end
      else begin exp_q1.delete(); exp_jk1.delete(); end
      return;
    end
    if (done_v[i]) begin
      done_seen[i]++;
      if ((i == 0 ? exp_q0.size() : exp_q1.size()) == 0) report_fail("done_without_request");
      else begin
        e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("resp%0d{err,rail,ecnt,xcnt}", i), act_resp(i), e);
      end
    end
    case (phase[i])
      0: check($sformatf("idle%0d{j,k,done,ready}", i), {j_v[i], k_v[i], done_v[i], ready_v[i]}, 4'b0001);
      1: begin
        if ((i == 0 ? exp_jk0.size() : exp_jk1.size()) == 0) report_fail("excite_queue_empty");
        else begin
          ejk = (i == 0) ? exp_jk0.pop_front() : exp_jk1.pop_front();
          check($sformatf("excite%0d{j,k}", i), {j_v[i], k_v[i]}, ejk);
        end
        check($sformatf("drive%0d{done,ready}", i), {done_v[i], ready_v[i]}, 2'b00);
      end
      2: check($sformatf("check%0d{j,k,done,ready}", i), {j_v[i], k_v[i], done_v[i], ready_v[i]}, 4'b0000);
      default: check($sformatf("done%0d{done,ready,j,k}", i), {done_v[i], ready_v[i], j_v[i], k_v[i]}, 4'b1100);
    endcase
    if (valid_v[i] && ready_v[i]) begin
      model_accept(i);
      phase[i] = 1;
    end else if (phase[i] != 0) begin
      phase[i] = (phase[i] == 3) ? 0 : phase[i] + 1;
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      mon_step(0);
      mon_step(1);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_q(int i, logic v);
    @(posedge clk); #2;
    pre_en[i] = 1'b1; pre_val[i] = v;
    @(posedge clk); #2;
    pre_en[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Wait (bounded) until the request on instance i will be accepted next edge.
  task automatic wait_accept(int i, output bit ok);
    ok = 1'b0;
    for (int b = 0; b < 20; b++) begin
      @(negedge clk);
      if (ready_v[i]) begin ok = 1'b1; break; end
    end
    if (!ok) report_fail("accept_timeout");
  endtask

  // One request; poke re-asserts valid while busy, which must be ignored.
  task automatic send(int i, logic t, logic poke);
    bit ok;
    @(posedge clk); #2;
    tgt_v[i] = t; valid_v[i] = 1'b1;
    wait_accept(i, ok);
    @(posedge clk); #2;
    valid_v[i] = ok ? poke : 1'b0; tgt_v[i] = ~t;
    @(posedge clk); #2;
    valid_v[i] = 1'b0;
    @(posedge clk); #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0, acc[4];
    bit ok;
    for (int i = 0; i < 2; i++) begin
      phase[i] = 0; done_seen[i] = 0; m_ecnt[i] = 0; m_xcnt[i] = 0; m_rail[i] = 1'b0;
    end
    fork monitor(); join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst0{ready,j,k,done,err,rail}", {ready_v[0], j0, k0, done0, err0, rail0}, 6'b100000);
    check("rst1{ready,j,k,done,err,rail}", {ready_v[1], j1, k1, done1, err1, rail1}, 6'b100000);
    check("rst_cnts", {ecnt0, xcnt0, ecnt1, xcnt1}, 20'h0);
    #1 rst_n = 1'b1;

    // q=0, tgt=1 on hold/set/reset coding
    send(0, 1'b1, 1'b0);
    check("first_xfer_cnt", xcnt0, 8'd1);

    // q=1, tgt=0 on toggle coding
    set_q(1, 1'b1);
    send(1, 1'b0, 1'b0);

    // Rails tied low: fails even though q matches target; flag is sticky
    rail[0] = 1'b1;
    send(0, 1'b0, 1'b0);
    rail[0] = 1'b0;
    send(0, $urandom_range(0, 1), 1'b0);
    check("rail_sticky", rail0, 1'b1);
    check("rail_err_cnt", ecnt0, 8'd1);

    // Saturation and wrap with 2-bit counters
    do_reset();
    set_q(1, 1'b0);
    stuck[1] = 1'b1;
    for (int n = 0; n < 5; n++) send(1, 1'b1, 1'b0);
    stuck[1] = 1'b0;
    check("sat_err_cnt", ecnt1, 2'd3);
    check("wrap_xfer_cnt", xcnt1, 2'd1);

    // tgt_valid held high: one accept every 3 cycles, 4 done pulses
    @(posedge clk); #2;
    d0 = done_seen[0];
    tgt_v[0] = 1'($urandom_range(0, 1)); valid_v[0] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      wait_accept(0, ok);
      acc[n] = cyc;
      @(posedge clk); #2;
      tgt_v[0] = 1'($urandom_range(0, 1));
    end
    valid_v[0] = 1'b0;
    for (int n = 1; n < 4; n++) check("accept_spacing", acc[n] - acc[n-1], 3);
    repeat (4) @(posedge clk);
    #2 check("stream_done_pulses", done_seen[0] - d0, 4);

    // Randomized traffic with occasional faults and busy-time pokes
    for (int n = 0; n < 40; n++) begin
      int i;
      i = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) set_q(i, 1'($urandom_range(0, 1)));
      stuck[i] = ($urandom_range(0, 9) == 0);
      rail[i]  = ($urandom_range(0, 9) == 0);
      send(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      stuck[i] = 1'b0;
      rail[i]  = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Reset in the middle of DRIVE drops the request
    set_q(0, 1'b0);
    @(posedge clk); #2;
    tgt_v[0] = 1'b1; valid_v[0] = 1'b1;
    wait_accept(0, ok);
    @(posedge clk); #2;
    valid_v[0] = 1'b0;
    d0 = done_seen[0];
    check("pre_reset_drive_j", j0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst{j,k,ready,done,err,rail}", {j0, k0, ready_v[0], done0, err0, rail0}, 6'b001000);
    check("mid_rst_cnts", {ecnt0, xcnt0}, 16'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2 check("no_done_after_reset", done_seen[0] - d0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
